// File: rtl/cam_capture_ds.sv
// Camera byte-stream capture with X/Y decimation into an RGB332 frame-buffer write port.
// Optional per-frame statistics outputs are enabled by defining CAM_CAPTURE_STATS_EN.
module cam_capture_ds #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15,
    parameter int DECIM_X       = 1,
    parameter int DECIM_Y       = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        DATA,
    input  logic              FMT,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        PIXEL_OUT,
    output logic              FRAME_DONE,
    output logic              OVF
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [ADDR_W-1:0] STAT_PIXELS,
    output logic [7:0]        STAT_LINES
`endif
);
    localparam int XW = $clog2(SCREEN_WIDTH + 1);
    localparam int YW = $clog2(SCREEN_HEIGHT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LINE_WAIT, S_BYTE1, S_BYTE0} state_t;

    state_t            state_q, state_d;
    logic              vs_q, href_q;
    logic              fmt_q, fmt_d;
    logic [6:0]        b0_q, b0_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [2:0]        cx_q, cx_d, cy_q, cy_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              line_pix_q, line_pix_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        pix_q, pix_d;
    logic              fd_q, fd_d, ovf_q, ovf_d;
    logic              vs_rise, href_fall, kept, in_range;
    logic [7:0]        pix_conv;
    logic [2:0]        cx_wrap, cy_wrap;

    assign vs_rise   = VSYNC & ~vs_q;
    assign href_fall = href_q & ~HREF;
    // byte0 keeps only the bits either format needs: {DATA[7:5], DATA[3:0]}
    assign pix_conv  = fmt_q ? {b0_q[3:1], DATA[7:5], DATA[3:2]}
                             : {b0_q[6:4], b0_q[2:0], DATA[4:3]};
    assign kept      = (cx_q == 3'd0) && (cy_q == 3'd0);
    assign in_range  = (x_q < XW'(SCREEN_WIDTH)) && (y_q < YW'(SCREEN_HEIGHT));
    assign cx_wrap   = (cx_q == 3'(DECIM_X - 1)) ? 3'd0 : cx_q + 3'd1;
    assign cy_wrap   = (cy_q == 3'(DECIM_Y - 1)) ? 3'd0 : cy_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        fmt_d      = fmt_q;
        b0_d       = b0_q;
        x_d        = x_q;
        y_d        = y_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        base_d     = base_q;
        line_pix_d = line_pix_q;
        w_en_d     = 1'b0;
        w_addr_d   = w_addr_q;
        pix_d      = pix_q;
        fd_d       = 1'b0;
        ovf_d      = ovf_q;
        if (vs_rise) begin
            fd_d       = (state_q != S_IDLE);
            state_d    = S_LINE_WAIT;
            fmt_d      = FMT;
            x_d        = '0;
            y_d        = '0;
            cx_d       = '0;
            cy_d       = '0;
            base_d     = '0;
            line_pix_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_LINE_WAIT: begin
                    if (HREF) begin
                        b0_d    = {DATA[7:5], DATA[3:0]};
                        state_d = S_BYTE1;
                    end
                end
                S_BYTE1, S_BYTE0: begin
                    if (VSYNC) begin
                        // frame sync inside a line: drop the line without advancing y
                        state_d    = S_LINE_WAIT;
                        x_d        = '0;
                        cx_d       = '0;
                        line_pix_d = 1'b0;
                    end else if (!HREF) begin
                        state_d = S_LINE_WAIT;
                        if (href_fall && line_pix_q) begin
                            x_d        = '0;
                            cx_d       = '0;
                            line_pix_d = 1'b0;
                            cy_d       = cy_wrap;
                            if (cy_q == 3'd0 && y_q < YW'(SCREEN_HEIGHT)) begin
                                y_d    = y_q + YW'(1);
                                base_d = base_q + ADDR_W'(SCREEN_WIDTH);
                            end
                        end
                    end else if (state_q == S_BYTE0) begin
                        b0_d    = {DATA[7:5], DATA[3:0]};
                        state_d = S_BYTE1;
                    end else begin
                        state_d    = S_BYTE0;
                        line_pix_d = 1'b1;
                        cx_d       = cx_wrap;
                        if (kept) begin
                            if (in_range) begin
                                w_en_d   = 1'b1;
                                w_addr_d = base_q + ADDR_W'(x_q);
                                pix_d    = pix_conv;
                                x_d      = x_q + XW'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            vs_q       <= 1'b0;
            href_q     <= 1'b0;
            fmt_q      <= 1'b0;
            b0_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            base_q     <= '0;
            line_pix_q <= 1'b0;
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            pix_q      <= '0;
            fd_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= VSYNC;
            href_q     <= HREF;
            fmt_q      <= fmt_d;
            b0_q       <= b0_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            base_q     <= base_d;
            line_pix_q <= line_pix_d;
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            pix_q      <= pix_d;
            fd_q       <= fd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign W_EN       = w_en_q;
    assign W_ADDR     = w_addr_q;
    assign PIXEL_OUT  = pix_q;
    assign FRAME_DONE = fd_q;
    assign OVF        = ovf_q;

`ifdef CAM_CAPTURE_STATS_EN
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d, stat_pix_q, stat_pix_d;
    logic [7:0]        line_cnt_q, line_cnt_d, stat_lines_q, stat_lines_d;
    logic              line_end;

    assign line_end = !vs_rise && (state_q == S_BYTE0 || state_q == S_BYTE1)
                      && !VSYNC && href_fall && line_pix_q;

    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        stat_pix_d   = stat_pix_q;
        stat_lines_d = stat_lines_q;
        if (vs_rise) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            if (state_q != S_IDLE) begin
                stat_pix_d   = pix_cnt_q;
                stat_lines_d = line_cnt_q;
            end
        end else begin
            if (w_en_d)
                pix_cnt_d = pix_cnt_q + ADDR_W'(1);
            if (line_end && line_cnt_q != 8'hFF)
                line_cnt_d = line_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            stat_pix_q   <= '0;
            stat_lines_q <= '0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            stat_pix_q   <= stat_pix_d;
            stat_lines_q <= stat_lines_d;
        end
    end

    assign STAT_PIXELS = stat_pix_q;
    assign STAT_LINES  = stat_lines_q;
`endif

endmodule

// File: tb/tb_cam_capture_ds.sv
// Bench for cam_capture_ds: two instances (no decimation, 2x2 decimation) checked against a
// frame/line/byte-count model every cycle, plus literal expectations per directed scenario.
module tb_cam_capture_ds;
    localparam int W  = 176;
    localparam int H  = 144;
    localparam int AW = 15;

    logic clk = 0, rst_n = 0, vsync = 0, href = 0, fmt = 0;
    logic [7:0] data = 0;
    logic wen0, wen1, fd0, fd1, ovf0, ovf1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0] pix0, pix1;
`ifdef CAM_CAPTURE_STATS_EN
    logic [AW-1:0] sp0, sp1;
    logic [7:0] sl0, sl1;
`endif

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    cam_capture_ds #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW), .DECIM_X(1), .DECIM_Y(1)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .VSYNC(vsync), .HREF(href), .DATA(data), .FMT(fmt),
        .W_EN(wen0), .W_ADDR(addr0), .PIXEL_OUT(pix0), .FRAME_DONE(fd0), .OVF(ovf0)
`ifdef CAM_CAPTURE_STATS_EN
        , .STAT_PIXELS(sp0), .STAT_LINES(sl0)
`endif
    );

    cam_capture_ds #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW), .DECIM_X(2), .DECIM_Y(2)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .VSYNC(vsync), .HREF(href), .DATA(data), .FMT(fmt),
        .W_EN(wen1), .W_ADDR(addr1), .PIXEL_OUT(pix1), .FRAME_DONE(fd1), .OVF(ovf1)
`ifdef CAM_CAPTURE_STATS_EN
        , .STAT_PIXELS(sp1), .STAT_LINES(sl1)
`endif
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] conv(logic [7:0] b0, logic [7:0] b1, bit f);
        return f ? {b0[3:1], b1[7:5], b1[3:2]} : {b0[7:5], b0[2:0], b1[4:3]};
    endfunction

    // Model: per frame, count completed non-empty lines and bytes in the current line.
    int   dx[2] = '{1, 2};
    int   dy[2] = '{1, 2};
    bit   in_frame[2];
    bit   mfmt[2];
    int   nb[2], nl[2];
    logic [7:0] mb0[2];
    bit   exp_wen[2], exp_fd[2], exp_ovf[2];
    int   exp_addr[2];
    logic [7:0] exp_pix[2];
    bit   vs_prev, h_prev;
    int   mp, mx, my;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                in_frame[k] = 0; nb[k] = 0; nl[k] = 0; mfmt[k] = 0;
                exp_wen[k] = 0; exp_fd[k] = 0; exp_ovf[k] = 0; exp_addr[k] = 0; exp_pix[k] = 0;
            end
            vs_prev = 0; h_prev = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_wen[k] = 0;
                exp_fd[k]  = 0;
                if (vsync && !vs_prev) begin
                    exp_fd[k] = in_frame[k];
                    in_frame[k] = 1; mfmt[k] = fmt; nb[k] = 0; nl[k] = 0; exp_ovf[k] = 0;
                end else if (in_frame[k]) begin
                    if (href) begin
                        if (nb[k] % 2 == 0) mb0[k] = data;
                        else begin
                            mp = nb[k] / 2;
                            if (mp % dx[k] == 0 && nl[k] % dy[k] == 0) begin
                                mx = mp / dx[k];
                                my = nl[k] / dy[k];
                                if (mx < W && my < H) begin
                                    exp_wen[k]  = 1;
                                    exp_addr[k] = my * W + mx;
                                    exp_pix[k]  = conv(mb0[k], data, mfmt[k]);
                                end else exp_ovf[k] = 1;
                            end
                        end
                        nb[k]++;
                    end else if (h_prev) begin
                        if (nb[k] >= 2) nl[k]++;
                        nb[k] = 0;
                    end
                end
            end
            vs_prev = vsync;
            h_prev  = href;
        end
    end

    int qa0[$], qp0[$], qa1[$];

    always @(negedge clk) begin
        chk("w_en0", wen0, exp_wen[0]);
        chk("w_addr0", addr0, exp_addr[0]);
        chk("pixel0", pix0, exp_pix[0]);
        chk("frame_done0", fd0, exp_fd[0]);
        chk("ovf0", ovf0, exp_ovf[0]);
        chk("w_en1", wen1, exp_wen[1]);
        chk("w_addr1", addr1, exp_addr[1]);
        chk("pixel1", pix1, exp_pix[1]);
        chk("frame_done1", fd1, exp_fd[1]);
        chk("ovf1", ovf1, exp_ovf[1]);
        if (wen0 === 1'b1) begin qa0.push_back(int'(addr0)); qp0.push_back(int'(pix0)); end
        if (wen1 === 1'b1) qa1.push_back(int'(addr1));
    end

    logic [7:0] lb[$];

    task automatic drv(input logic v, input logic h, input logic [7:0] d);
        vsync = v; href = h; data = d;
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) drv(0, 0, 8'h00);
    endtask

    task automatic vs_pulse();
        drv(1, 0, 8'h00); drv(1, 0, 8'h00); gap(2);
    endtask

    task automatic send_line();
        foreach (lb[i]) drv(0, 1, lb[i]);
        gap(3);
    endtask

    task automatic clearq();
        qa0.delete(); qp0.delete(); qa1.delete();
    endtask

    initial begin
        #1_500_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int mx_addr;
        repeat (3) @(negedge clk);
        chk("rst_w_en", wen0, 0);
        chk("rst_w_addr", addr0, 0);
        chk("rst_pixel", pix0, 0);
        chk("rst_ovf", ovf0, 0);
        rst_n = 1;
        gap(2);

        // RGB565 single line
        fmt = 0;
        drv(1, 0, 8'h00);
        chk("first_vsync_no_done", fd0, 0);
        drv(1, 0, 8'h00); gap(2);
        clearq();
        lb = {8'hE0, 8'h1F, 8'h07, 8'hE0};
        send_line();
        chk("t1_nwrites", qa0.size(), 2);
        chk("t1_addr0", qa0[0], 0);
        chk("t1_pix0", qp0[0], 8'hE3);
        chk("t1_addr1", qa0[1], 1);
        chk("t1_pix1", qp0[1], 8'h1C);
        chk("t1_ovf", ovf0, 0);
        drv(1, 0, 8'h00);
        chk("t1_frame_done", fd0, 1);
        drv(1, 0, 8'h00);
        chk("t1_frame_done_width", fd0, 0);
        gap(2);

        // RGB444, FMT toggled mid-frame
        fmt = 1;
        vs_pulse();
        clearq();
        lb = {8'h0F, 8'hFF};
        send_line();
        fmt = 0;
        send_line();
        chk("t2_nwrites", qa0.size(), 2);
        chk("t2_addr0", qa0[0], 0);
        chk("t2_pix0", qp0[0], 8'hFF);
        chk("t2_addr1", qa0[1], W);
        chk("t2_pix1_fmt_held", qp0[1], 8'hFF);

        // 2x2 decimation on dut1
        vs_pulse();
        clearq();
        lb.delete();
        for (int i = 0; i < 16; i++) lb.push_back(8'(i * 17 + 3));
        repeat (4) send_line();
        chk("t4_nwrites", qa1.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < qa1.size()) chk("t4_addr", qa1[i], (i < 4) ? i : W + i - 4);
        send_line();
        chk("t4_y2_addr", (qa1.size() > 8) ? qa1[8] : -1, 2 * W);

        // Odd byte count
        vs_pulse();
        clearq();
        lb = {8'h12, 8'h34, 8'h56};
        send_line();
        lb = {8'hAB, 8'hCD};
        send_line();
        chk("t5_nwrites", qa0.size(), 2);
        chk("t5_addr0", qa0[0], 0);
        chk("t5_pix0", qp0[0], 8'h0A);
        chk("t5_addr1", qa0[1], W);
        chk("t5_pix1", qp0[1], 8'hAD);

        // Reset mid-line
        vs_pulse();
        lb = {8'h11, 8'h22};
        send_line();
        drv(0, 1, 8'h55); drv(0, 1, 8'h66);
        chk("t6_pre_addr", addr0, W);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_w_en", wen0, 0);
        chk("t6_rst_addr", addr0, 0);
        chk("t6_rst_pixel", pix0, 0);
        drv(0, 1, 8'h77);
        rst_n = 1;
        clearq();
        lb.delete();
        for (int i = 0; i < 8; i++) lb.push_back(8'(i + 1));
        send_line();
        chk("t6_no_write0", qa0.size(), 0);
        chk("t6_no_write1", qa1.size(), 0);
        vs_pulse();
        lb = {8'hE0, 8'h1F};
        send_line();
        chk("t6_resume_n", qa0.size(), 1);
        chk("t6_resume_pix", (qp0.size() > 0) ? qp0[0] : -1, 8'hE3);

        // Full frame with overflow in both directions
        fmt = 0;
        vs_pulse();
        clearq();
        for (int ln = 0; ln < 150; ln++) begin
            for (int i = 0; i < 360; i++) drv(0, 1, 8'(i * 3 + ln));
            gap(2);
        end
        chk("t3_nwrites", qa0.size(), W * H);
        chk("t3_last_addr", (qa0.size() > 0) ? qa0[$] : -1, W * H - 1);
        mx_addr = 0;
        foreach (qa0[i]) if (qa0[i] > mx_addr) mx_addr = qa0[i];
        chk("t3_max_addr_in_range", (mx_addr < W * H) ? 1 : 0, 1);
        chk("t3_ovf", ovf0, 1);
        chk("t3_decim_nwrites", qa1.size(), 90 * 75);
        drv(1, 0, 8'h00);
        chk("t3_frame_done", fd0, 1);
        drv(1, 0, 8'h00);
        gap(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
